// File: rtl/bru_pkg.sv
// bru_pkg: shared encodings for the branch resolve unit.
// Op encoding is 3 bits wide; 3'b111 is reserved and treated as illegal.
package bru_pkg;

    localparam int BRU_OP_W = 3;

    localparam logic [BRU_OP_W-1:0] OP_BEQ  = 3'b000;
    localparam logic [BRU_OP_W-1:0] OP_BNE  = 3'b001;
    localparam logic [BRU_OP_W-1:0] OP_BLT  = 3'b010;
    localparam logic [BRU_OP_W-1:0] OP_BGE  = 3'b011;
    localparam logic [BRU_OP_W-1:0] OP_BLTU = 3'b100;
    localparam logic [BRU_OP_W-1:0] OP_BGEU = 3'b101;
    localparam logic [BRU_OP_W-1:0] OP_JMP  = 3'b110;
    localparam logic [BRU_OP_W-1:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/branch_compare.sv
// branch_compare: combinational condition evaluation for one branch op.
// cond is the raw "taken" decision; the reserved encoding yields cond=0 and
// raises illegal so the pipeline can report it.
module branch_compare
    import bru_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [BRU_OP_W-1:0] op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic                cond,
    output logic                illegal
);

    // Decode the op into a taken condition and an illegal flag.
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_BEQ:  cond = (a == b);
            OP_BNE:  cond = (a != b);
            OP_BLT:  cond = ($signed(a) <  $signed(b));
            OP_BGE:  cond = ($signed(a) >= $signed(b));
            OP_BLTU: cond = (a <  b);
            OP_BGEU: cond = (a >= b);
            OP_JMP:  cond = 1'b1;
            OP_RSVD: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage registered branch/jump resolver.
// Stage 1 captures the compare result and PC/offset; stage 2 forms the
// redirect PC and the mispredict flag. A consumed mispredict raises flush,
// which also squashes the younger op in stage 1 and any op accepted in the
// same cycle. stall freezes everything.
// Optional build macro BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int OFF_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BRU_OP_W-1:0] in_op,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [OFF_W-1:0]    in_offset,
    input  logic                in_pred_taken,
    input  logic                stall,
    output logic                out_valid,
    output logic                out_taken,
    output logic [PC_W-1:0]     out_redirect,
    output logic                out_mispredict,
    output logic                out_illegal,
    output logic                flush
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispredicts
`endif
);

    localparam int EXT_W = PC_W - OFF_W;

    // Handshake and control
    logic accept_s;
    logic consume_s;
    logic kill_s;

    // Stage 1 inputs from the comparator
    logic            cmp_cond_s;
    logic            cmp_illegal_s;
    logic [PC_W-1:0] off_ext_s;

    // Stage 1 registers
    logic            s1_valid_r;
    logic            s1_cond_r;
    logic            s1_illegal_r;
    logic            s1_pred_r;
    logic [PC_W-1:0] s1_pc_r;
    logic [PC_W-1:0] s1_off_r;

    // Stage 2 next-state values
    logic            s2_load_s;
    logic            s2_taken_s;
    logic            s2_mispredict_s;
    logic [PC_W-1:0] fall_through_s;
    logic [PC_W-1:0] target_s;
    logic [PC_W-1:0] s2_redirect_s;

    // Stage 2 registers (drive the outputs)
    logic            s2_valid_r;
    logic            s2_taken_r;
    logic            s2_mispredict_r;
    logic            s2_illegal_r;
    logic [PC_W-1:0] s2_redirect_r;

    assign in_ready  = ~stall;
    assign accept_s  = in_valid & ~stall;
    assign consume_s = s2_valid_r & ~stall;
    assign flush     = consume_s & s2_mispredict_r;
    assign kill_s    = flush;
    assign off_ext_s = {{EXT_W{in_offset[OFF_W-1]}}, in_offset};
    assign s2_load_s = s1_valid_r & ~kill_s;

    assign out_valid      = s2_valid_r;
    assign out_taken      = s2_taken_r;
    assign out_redirect   = s2_redirect_r;
    assign out_mispredict = s2_mispredict_r;
    assign out_illegal    = s2_illegal_r;

    branch_compare #(
        .DATA_W (DATA_W)
    ) u_compare (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .cond    (cmp_cond_s),
        .illegal (cmp_illegal_s)
    );

    // Stage 1: capture an accepted op unless a flush kills it this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_cond_r    <= 1'b0;
            s1_illegal_r <= 1'b0;
            s1_pred_r    <= 1'b0;
            s1_pc_r      <= {PC_W{1'b0}};
            s1_off_r     <= {PC_W{1'b0}};
        end else if (!stall) begin
            s1_valid_r <= accept_s & ~kill_s;
            if (accept_s) begin
                s1_cond_r    <= cmp_cond_s;
                s1_illegal_r <= cmp_illegal_s;
                s1_pred_r    <= in_pred_taken;
                s1_pc_r      <= in_pc;
                s1_off_r     <= off_ext_s;
            end
        end
    end

    // Stage 2 datapath: fall-through and target both wrap modulo 2^PC_W.
    always_comb begin
        fall_through_s  = s1_pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        target_s        = fall_through_s + s1_off_r;
        s2_taken_s      = s1_cond_r & ~s1_illegal_r;
        s2_mispredict_s = s2_taken_s ^ s1_pred_r;
        if (s2_taken_s) begin
            s2_redirect_s = target_s;
        end else begin
            s2_redirect_s = fall_through_s;
        end
    end

    // Stage 2: register the resolved result; hold everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r      <= 1'b0;
            s2_taken_r      <= 1'b0;
            s2_mispredict_r <= 1'b0;
            s2_illegal_r    <= 1'b0;
            s2_redirect_r   <= {PC_W{1'b0}};
        end else if (!stall) begin
            s2_valid_r <= s2_load_s;
            if (s2_load_s) begin
                s2_taken_r      <= s2_taken_s;
                s2_mispredict_r <= s2_mispredict_s;
                s2_illegal_r    <= s1_illegal_r;
                s2_redirect_r   <= s2_redirect_s;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [31:0] stat_branches_r;
    logic [31:0] stat_mispredicts_r;

    assign stat_branches    = stat_branches_r;
    assign stat_mispredicts = stat_mispredicts_r;

    // Saturating counters of consumed results and consumed mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_r    <= 32'd0;
            stat_mispredicts_r <= 32'd0;
        end else if (consume_s) begin
            if (stat_branches_r != 32'hFFFF_FFFF) begin
                stat_branches_r <= stat_branches_r + 32'd1;
            end
            if (s2_mispredict_r && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
                stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + randomized bench for branch_resolve_unit.
// The reference model is a queue of in-flight ops whose results are computed
// from the branch rules with plain arithmetic; a consumed mispredict empties
// the queue (all younger ops are squashed).
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int DATA_W = 16;
    localparam int PC_W   = 16;
    localparam int OFF_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [PC_W-1:0]   in_pc;
    logic [OFF_W-1:0]  in_offset;
    logic              in_pred_taken;
    logic              stall;
    logic              out_valid;
    logic              out_taken;
    logic [PC_W-1:0]   out_redirect;
    logic              out_mispredict;
    logic              out_illegal;
    logic              flush;
`ifdef BRU_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .OFF_W  (OFF_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_pc          (in_pc),
        .in_offset      (in_offset),
        .in_pred_taken  (in_pred_taken),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_taken      (out_taken),
        .out_redirect   (out_redirect),
        .out_mispredict (out_mispredict),
        .out_illegal    (out_illegal),
        .flush          (flush)
`ifdef BRU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        logic            taken;
        logic [PC_W-1:0] redirect;
        logic            mis;
        logic            ill;
        int              age;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int n_consumed = 0;
    int n_flush = 0;
    int stat_b = 0;
    int stat_m = 0;
    logic            last_taken;
    logic [PC_W-1:0] last_redirect;
    logic            last_mis;
    logic            last_ill;

    // Reference rules: condition per mode, target = pc+1+sext(off) wrapping.
    function automatic exp_t ref_resolve(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] pc,
                                         input logic [7:0] off, input logic pred);
        exp_t e;
        int sa, sb, so;
        sa = $signed(a);
        sb = $signed(b);
        so = $signed(off);
        e.ill = 1'b0;
        case (op)
            3'd0: e.taken = (a == b);
            3'd1: e.taken = (a != b);
            3'd2: e.taken = (sa < sb);
            3'd3: e.taken = (sa >= sb);
            3'd4: e.taken = (int'(a) < int'(b));
            3'd5: e.taken = (int'(a) >= int'(b));
            3'd6: e.taken = 1'b1;
            default: begin e.taken = 1'b0; e.ill = 1'b1; end
        endcase
        if (e.taken) e.redirect = 16'((int'(pc) + 1 + so) % 65536);
        else         e.redirect = 16'((int'(pc) + 1) % 65536);
        e.mis = (e.taken != pred);
        e.age = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock.
    task automatic cycle(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] pc, input logic [7:0] off,
                         input logic pred, input logic st);
        exp_t e;
        logic exp_valid;
        logic squash;
        in_valid = v; in_op = op; in_a = a; in_b = b; in_pc = pc;
        in_offset = off; in_pred_taken = pred; stall = st;
        #1;
        exp_valid = 1'b0;
        if (q.size() > 0) exp_valid = (q[0].age >= 2);
        chk("in_ready", {31'd0, in_ready}, {31'd0, ~st});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
`ifdef BRU_STATS_EN
        chk("stat_branches", stat_branches, stat_b);
        chk("stat_mispredicts", stat_mispredicts, stat_m);
`endif
        if (flush === 1'b1) n_flush++;
        squash = 1'b0;
        if (exp_valid && !st) begin
            e = q.pop_front();
            chk("taken", {31'd0, out_taken}, {31'd0, e.taken});
            chk("redirect", {16'd0, out_redirect}, {16'd0, e.redirect});
            chk("mispredict", {31'd0, out_mispredict}, {31'd0, e.mis});
            chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            chk("flush", {31'd0, flush}, {31'd0, e.mis});
            last_taken = out_taken; last_redirect = out_redirect;
            last_mis = out_mispredict; last_ill = out_illegal;
            n_consumed++;
            stat_b++;
            if (e.mis) begin
                stat_m++;
                squash = 1'b1;
                q.delete();
            end
        end else begin
            chk("flush_idle", {31'd0, flush}, 32'd0);
        end
        if (!st) begin
            foreach (q[i]) q[i].age++;
            if (v && !squash) begin
                e = ref_resolve(op, a, b, pc, off, pred);
                e.age = 1;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 16'd0, 16'd0, 16'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] pc, input logic [7:0] off, input logic pred);
        cycle(1'b1, op, a, b, pc, off, pred, 1'b0);
        idle(3);
    endtask

    // Reset for two cycles with in_valid held high.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b1; stall = 1'b0;
        in_op = 3'd6; in_pred_taken = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("rst_redirect", {16'd0, out_redirect}, 32'd0);
        chk("rst_taken", {31'd0, out_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        stat_b = 0; stat_m = 0;
        #1;
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rel_flush", {31'd0, flush}, 32'd0);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    // Directed steps followed by a randomized burst.
    initial begin
        int c0, f0;
        logic [PC_W+3:0] snap;
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 16'd0; in_b = 16'd0;
        in_pc = 16'd0; in_offset = 8'd0; in_pred_taken = 1'b0; stall = 1'b0;
        last_taken = 1'b0; last_redirect = 16'd0; last_mis = 1'b0; last_ill = 1'b0;
        @(negedge clk);
        do_reset();

        // Mode sweep, pred=0
        issue(3'd0, 16'h1234, 16'h1234, 16'h0100, 8'h04, 1'b0);
        issue(3'd1, 16'h0005, 16'h0005, 16'h0101, 8'h04, 1'b0);
        chk("bne_taken", {31'd0, last_taken}, 32'd0);
        chk("bne_redirect", {16'd0, last_redirect}, 32'h0102);
        issue(3'd2, 16'hFFFF, 16'h0001, 16'h0102, 8'h04, 1'b0);
        chk("blt_taken", {31'd0, last_taken}, 32'd1);
        chk("blt_redirect", {16'd0, last_redirect}, 32'h0107);
        issue(3'd3, 16'h8000, 16'h7FFF, 16'h0103, 8'h04, 1'b0);
        issue(3'd4, 16'hFFFF, 16'h0001, 16'h0104, 8'h04, 1'b0);
        chk("bltu_taken", {31'd0, last_taken}, 32'd0);
        issue(3'd5, 16'hFFFF, 16'h0001, 16'h0105, 8'h04, 1'b0);
        issue(3'd6, 16'h0000, 16'h0000, 16'h0106, 8'hFC, 1'b0);
        issue(3'd7, 16'h0001, 16'h0001, 16'h0107, 8'h04, 1'b1);
        chk("rsvd_illegal", {31'd0, last_ill}, 32'd1);
        chk("rsvd_redirect", {16'd0, last_redirect}, 32'h0108);
        chk("rsvd_mis", {31'd0, last_mis}, 32'd1);

        // Target wrap
        issue(3'd6, 16'd0, 16'd0, 16'hFFFE, 8'h01, 1'b1);
        chk("wrap_redirect", {16'd0, last_redirect}, 32'h0000);
        chk("wrap_taken", {31'd0, last_taken}, 32'd1);
        issue(3'd6, 16'd0, 16'd0, 16'h0010, 8'h80, 1'b1);
        chk("negoff_redirect", {16'd0, last_redirect}, 32'hFF91);

        // Mispredict squash: 4 ops back to back, ops 2 and 3 are squashed
        c0 = n_consumed; f0 = n_flush;
        cycle(1'b1, 3'd0, 16'h0007, 16'h0007, 16'h0200, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 3'd6, 16'h0000, 16'h0000, 16'h0300, 8'h10, 1'b1, 1'b0);
        cycle(1'b1, 3'd6, 16'h0000, 16'h0000, 16'h0400, 8'h10, 1'b1, 1'b0);
        cycle(1'b1, 3'd0, 16'h0001, 16'h0002, 16'h0500, 8'h10, 1'b0, 1'b0);
        idle(4);
        chk("squash_consumed", n_consumed - c0, 32'd2);
        chk("squash_flushes", n_flush - f0, 32'd1);
        chk("squash_last_redirect", {16'd0, last_redirect}, 32'h0501);

        // Stall while s2 holds a mispredict
        f0 = n_flush;
        cycle(1'b1, 3'd0, 16'h0003, 16'h0003, 16'h0600, 8'h08, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        snap = {out_valid, out_taken, out_mispredict, out_illegal, out_redirect};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 3'd6, 16'h0000, 16'h0000, 16'h0700, 8'h01, 1'b0, 1'b1);
            chk("stall_hold", {12'd0, out_valid, out_taken, out_mispredict, out_illegal, out_redirect},
                {12'd0, snap});
        end
        chk("stall_no_flush", n_flush - f0, 32'd0);
        cycle(1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        chk("stall_release_flush", n_flush - f0, 32'd1);
        idle(3);

        // Reset mid-operation: in-flight ops vanish without a flush
        cycle(1'b1, 3'd0, 16'h0009, 16'h0009, 16'h0800, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 16'h0009, 16'h0008, 16'h0801, 8'h02, 1'b0, 1'b0);
        do_reset();
        idle(3);

        // Randomized burst
        for (int n = 0; n < 400; n++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = (($urandom % 4) == 0) ? ra : 16'($urandom);
            cycle(1'(($urandom % 4) != 0), 3'($urandom), ra, rb, 16'($urandom),
                  8'($urandom), 1'($urandom), 1'(($urandom % 5) == 0));
        end
        idle(4);
        chk("drain_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
